// File: rtl/rat_io_hub.sv
// rtl/rat_io_hub.sv - MCU port I/O hub: output registers, synchronised inputs, edge interrupts
// Interrupt logic is present only when RAT_IO_HUB_INTR_EN is defined; otherwise INTR is tied low.
module rat_io_hub #(
  parameter int         DATA_W      = 8,
  parameter int         NUM_OUT     = 4,
  parameter int         NUM_IN      = 4,
  parameter logic [7:0] OUT_BASE    = 8'h80,
  parameter logic [7:0] IN_BASE     = 8'h90,
  parameter logic [7:0] INTR_ID     = 8'hF0,
  parameter logic [7:0] INTR_CLR_ID = 8'hF1,
  parameter int         INTR_HOLD   = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [7:0]                PORT_ID,
  input  logic [DATA_W-1:0]         OUT_PORT,
  input  logic                      IO_STRB,
  output logic [DATA_W-1:0]         IN_PORT,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]         irq_src,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [NUM_OUT-1:0]        out_wr,
  output logic                      INTR
);

  logic [7:0]                w_out_off;
  logic [7:0]                w_in_off;
  logic [NUM_OUT*DATA_W-1:0] r_out_data;
  logic [NUM_OUT-1:0]        r_out_wr;
  logic [NUM_IN*DATA_W-1:0]  r_in_s1;
  logic [NUM_IN*DATA_W-1:0]  r_in_s2;
  logic [DATA_W-1:0]         w_rd;

  assign w_out_off = PORT_ID - OUT_BASE;
  assign w_in_off  = PORT_ID - IN_BASE;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_out_data <= '0;
      r_out_wr   <= '0;
      r_in_s1    <= '0;
      r_in_s2    <= '0;
    end else begin
      r_in_s1  <= in_data;
      r_in_s2  <= r_in_s1;
      r_out_wr <= '0;
      if (IO_STRB) begin
        for (int k = 0; k < NUM_OUT; k++) begin
          if (w_out_off == 8'(k)) begin
            r_out_data[k*DATA_W +: DATA_W] <= OUT_PORT;
            r_out_wr[k]                    <= 1'b1;
          end
        end
      end
    end
  end

  assign out_data = r_out_data;
  assign out_wr   = r_out_wr;

`ifdef RAT_IO_HUB_INTR_EN
  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_WAIT_CLR} state_t;
  localparam int CW = (INTR_HOLD > 1) ? $clog2(INTR_HOLD) : 1;

  logic [NUM_IN-1:0] r_irq_s1;
  logic [NUM_IN-1:0] r_irq_s2;
  logic [NUM_IN-1:0] r_irq_d;
  logic [NUM_IN-1:0] r_pending;
  logic [NUM_IN-1:0] r_mask;
  logic [1:0]        r_arm_cnt;
  logic [CW-1:0]     r_hold;
  logic              r_intr;
  state_t            r_state;
  logic [NUM_IN-1:0] w_edge;
  logic [NUM_IN-1:0] w_clr_bits;
  logic              w_active;

  // Edges are suppressed until the synchroniser and history flop have refilled after reset,
  // so a source held high through reset release is not seen as a new request.
  assign w_edge     = r_irq_s2 & ~r_irq_d & {NUM_IN{r_arm_cnt == 2'd0}};
  assign w_clr_bits = (IO_STRB && PORT_ID == INTR_CLR_ID) ? NUM_IN'(OUT_PORT) : '0;
  assign w_active   = |(r_pending & r_mask);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_irq_s1  <= '0;
      r_irq_s2  <= '0;
      r_irq_d   <= '0;
      r_pending <= '0;
      r_mask    <= '0;
      r_arm_cnt <= 2'd3;
      r_hold    <= '0;
      r_intr    <= 1'b0;
      r_state   <= S_IDLE;
    end else begin
      r_irq_s1  <= irq_src;
      r_irq_s2  <= r_irq_s1;
      r_irq_d   <= r_irq_s2;
      if (r_arm_cnt != 2'd0) r_arm_cnt <= r_arm_cnt - 2'd1;
      r_pending <= (r_pending & ~w_clr_bits) | w_edge;
      if (IO_STRB && PORT_ID == INTR_ID) r_mask <= NUM_IN'(OUT_PORT);
      case (r_state)
        S_IDLE: if (w_active) begin
          r_state <= S_ASSERT;
          r_hold  <= CW'(INTR_HOLD - 1);
          r_intr  <= 1'b1;
        end
        S_ASSERT: if (r_hold == '0) begin
          r_state <= S_WAIT_CLR;
          r_intr  <= 1'b0;
        end else begin
          r_hold <= r_hold - CW'(1);
        end
        S_WAIT_CLR: if (!w_active) r_state <= S_IDLE;
        default: begin
          r_state <= S_IDLE;
          r_intr  <= 1'b0;
        end
      endcase
    end
  end

  assign INTR = r_intr;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{irq_src, INTR_HOLD[0]};
  assign INTR         = 1'b0;
`endif

  always_comb begin
    w_rd = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (w_in_off == 8'(k)) w_rd = r_in_s2[k*DATA_W +: DATA_W];
    end
`ifdef RAT_IO_HUB_INTR_EN
    if (PORT_ID == INTR_ID)          w_rd = DATA_W'(r_pending);
    else if (PORT_ID == INTR_CLR_ID) w_rd = DATA_W'(r_mask);
`else
    if (PORT_ID == INTR_ID || PORT_ID == INTR_CLR_ID) w_rd = '0;
`endif
  end

  assign IN_PORT = w_rd;

endmodule
